// File: rtl/bringup_reset_seq_pkg.sv
// Shared types for the bring-up reset sequencer: FSM encoding, LED bit map
// and the helper that builds the status LED pattern.
package bringup_reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam int LED_HB       = 0;
  localparam int LED_READY    = 1;
  localparam int LED_ERROR    = 2;
  localparam int LED_IN_RESET = 3;

  localparam int ERR_STAGE_W = 3;

  // Heartbeat: slow blink when done, fast blink while sequencing, steady on error.
  function automatic logic [3:0] led_pattern(input state_t st, input logic hb_slow,
                                             input logic hb_fast, input logic ready,
                                             input logic err, input logic in_reset);
    logic [3:0] led;
    led               = '0;
    led[LED_READY]    = ready;
    led[LED_ERROR]    = err;
    led[LED_IN_RESET] = in_reset;
    case (st)
      ST_DONE:  led[LED_HB] = hb_slow;
      ST_ERROR: led[LED_HB] = 1'b1;
      default:  led[LED_HB] = hb_fast;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/bringup_reset_seq_if.sv
// Control/status bundle between the reset sequencer and the board-level logic.
interface bringup_reset_seq_if #(
  parameter int NUM_STAGES = 4
);
  import bringup_reset_seq_pkg::*;

  // ext_reset_req is a one-cycle request with no back-pressure: it is acted on
  // at the next sys_clk edge. All status signals are registered in the sequencer.
  logic                   ext_reset_req;
  logic [NUM_STAGES-1:0]  stage_ready;
  logic [NUM_STAGES-1:0]  stage_reset_n;
  logic                   all_ready;
  logic                   seq_error;
  logic [ERR_STAGE_W-1:0] err_stage;
  logic [3:0]             status_led;
  state_t                 dbg_state;

  modport master (
    output ext_reset_req, stage_ready,
    input  stage_reset_n, all_ready, seq_error, err_stage, status_led, dbg_state
  );

  modport slave (
    input  ext_reset_req, stage_ready,
    output stage_reset_n, all_ready, seq_error, err_stage, status_led, dbg_state
  );

endinterface

// File: rtl/bringup_sync2.sv
// Two-flop synchroniser for asynchronous level inputs, reset to zero.
module bringup_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bringup_reset_seq.sv
// Power-on reset sequencer: releases reset domains in order, waits for each to
// report ready, flags a sticky error on timeout or ready drop, drives status LEDs.
module bringup_reset_seq
  import bringup_reset_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 256,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = 17,
  parameter int HB_W           = 32,
  parameter int HB_BIT         = 24
) (
  input logic               sys_clk,
  input logic               sys_reset,
  bringup_reset_seq_if.slave bus
);

  state_t                 state, state_nx;
  logic [ERR_STAGE_W-1:0] idx, idx_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [NUM_STAGES-1:0]  rst_n_q, rst_n_nx;
  logic                   all_ready_q, all_ready_nx;
  logic                   seq_error_q, seq_error_nx;
  logic [ERR_STAGE_W-1:0] err_stage_q, err_stage_nx;
  logic [3:0]             led_q, led_nx;
  logic [HB_W-1:0]        hb, hb_nx;

  logic [NUM_STAGES-1:0]  rdy_s;
  logic [NUM_STAGES-1:0]  idx_oh;
  logic                   rdy_cur;
  logic                   last_stage;
  logic [ERR_STAGE_W-1:0] low_zero;

  bringup_sync2 #(.W(NUM_STAGES)) u_sync (
    .clk (sys_clk),
    .rst (sys_reset),
    .d   (bus.stage_ready),
    .q   (rdy_s)
  );

  assign idx_oh     = NUM_STAGES'(1) << idx;
  assign rdy_cur    = |(rdy_s & idx_oh);
  assign last_stage = (idx == ERR_STAGE_W'(NUM_STAGES - 1));
  assign hb_nx      = hb + HB_W'(1);

  always_comb begin
    low_zero = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!rdy_s[i]) low_zero = ERR_STAGE_W'(i);
    end
  end

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    cnt_nx       = cnt;
    rst_n_nx     = rst_n_q;
    all_ready_nx = all_ready_q;
    seq_error_nx = seq_error_q;
    err_stage_nx = err_stage_q;
    if (bus.ext_reset_req) begin
      // Restart beats any ready/timeout/drop event in the same cycle.
      state_nx     = ST_HOLD;
      idx_nx       = '0;
      cnt_nx       = '0;
      rst_n_nx     = '0;
      all_ready_nx = 1'b0;
      seq_error_nx = 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            rst_n_nx = rst_n_q | idx_oh;
            cnt_nx   = '0;
            state_nx = ST_WAIT;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (rdy_cur) begin
            if (last_stage) begin
              state_nx     = ST_DONE;
              all_ready_nx = 1'b1;
            end else begin
              idx_nx   = idx + ERR_STAGE_W'(1);
              cnt_nx   = '0;
              state_nx = ST_HOLD;
            end
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_nx     = ST_ERROR;
            seq_error_nx = 1'b1;
            err_stage_nx = idx;
            rst_n_nx     = rst_n_q & ~idx_oh;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (!(&rdy_s)) begin
            state_nx     = ST_ERROR;
            seq_error_nx = 1'b1;
            err_stage_nx = low_zero;
            all_ready_nx = 1'b0;
          end
        end
        default: ;
      endcase
    end
    led_nx = led_pattern(state_nx, hb_nx[HB_BIT], hb_nx[HB_BIT-2], all_ready_nx,
                         seq_error_nx, ~&rst_n_nx);
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state       <= ST_HOLD;
      idx         <= '0;
      cnt         <= '0;
      rst_n_q     <= '0;
      all_ready_q <= 1'b0;
      seq_error_q <= 1'b0;
      err_stage_q <= '0;
      led_q       <= 4'b1000;
      hb          <= '0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      cnt         <= cnt_nx;
      rst_n_q     <= rst_n_nx;
      all_ready_q <= all_ready_nx;
      seq_error_q <= seq_error_nx;
      err_stage_q <= err_stage_nx;
      led_q       <= led_nx;
      hb          <= hb_nx;
    end
  end

  assign bus.stage_reset_n = rst_n_q;
  assign bus.all_ready     = all_ready_q;
  assign bus.seq_error     = seq_error_q;
  assign bus.err_stage     = err_stage_q;
  assign bus.status_led    = led_q;
  assign bus.dbg_state     = state;

endmodule

// File: tb/tb_bringup_reset_seq.sv
// Directed bench for bringup_reset_seq with 3 stages, short hold/timeout and a
// fast heartbeat tap; stage_ready follows the stage's own release, masked per test.
module tb_bringup_reset_seq;
  import bringup_reset_seq_pkg::*;

  localparam int NS   = 3;
  localparam int HOLD = 8;
  localparam int TO   = 16;
  localparam int CW   = 17;
  localparam int HBW  = 32;
  localparam int HBB  = 4;

  logic          sys_clk = 1'b0;
  logic          sys_reset = 1'b1;
  logic [NS-1:0] ready_en = '1;
  int            vectors = 0;
  int            miscompares = 0;
  int            hb_model = 0;

  always #5 sys_clk = ~sys_clk;

  bringup_reset_seq_if #(.NUM_STAGES(NS)) bus ();

  assign bus.stage_ready = bus.stage_reset_n & ready_en;

  bringup_reset_seq #(
    .NUM_STAGES     (NS),
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW),
    .HB_W           (HBW),
    .HB_BIT         (HBB)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .bus       (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each tick passes exactly one rising edge and lands on the following falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      hb_model++;
    end
  endtask

  task automatic do_reset();
    sys_reset = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_reset = 1'b0;
    hb_model  = 0;
  endtask

  // Clean sequence with ready looped back from each release; t0 = sequence start.
  task automatic run_clean(input string p);
    tick(7);
    check({p, "_rstn_t7"}, 32'(bus.stage_reset_n), 32'd0);
    tick(1);
    check({p, "_rstn_t8"}, 32'(bus.stage_reset_n), 32'd1);
    check({p, "_led_t8"}, 32'(bus.status_led), 32'({3'b100, hb_model[HBB-2]}));
    tick(10);
    check({p, "_rstn_t18"}, 32'(bus.stage_reset_n), 32'd1);
    tick(1);
    check({p, "_rstn_t19"}, 32'(bus.stage_reset_n), 32'd3);
    tick(10);
    check({p, "_rstn_t29"}, 32'(bus.stage_reset_n), 32'd3);
    tick(1);
    check({p, "_rstn_t30"}, 32'(bus.stage_reset_n), 32'd7);
    tick(2);
    check({p, "_rdy_t32"}, 32'(bus.all_ready), 32'd0);
    tick(1);
    check({p, "_rdy_t33"}, 32'(bus.all_ready), 32'd1);
    check({p, "_state_t33"}, 32'(bus.dbg_state), 32'(ST_DONE));
    check({p, "_led_t33"}, 32'(bus.status_led), 32'({3'b001, hb_model[HBB]}));
  endtask

  initial begin
    bus.ext_reset_req = 1'b0;
    repeat (2) @(negedge sys_clk);

    check("rst_rstn", 32'(bus.stage_reset_n), 32'd0);
    check("rst_all_ready", 32'(bus.all_ready), 32'd0);
    check("rst_seq_error", 32'(bus.seq_error), 32'd0);
    check("rst_err_stage", 32'(bus.err_stage), 32'd0);
    check("rst_led", 32'(bus.status_led), 32'h8);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_HOLD));

    // Clean power-on sequence, then the slow DONE blink.
    sys_reset = 1'b0;
    hb_model  = 0;
    run_clean("seq1");
    tick(14);
    check("done_led_47", 32'(bus.status_led), 32'h2);
    tick(1);
    check("done_led_48", 32'(bus.status_led), 32'h3);
    tick(16);
    check("done_led_64", 32'(bus.status_led), 32'h2);

    // Drop ready on stages 2 and 0 together while DONE.
    ready_en = 3'b010;
    tick(2);
    check("drop_rdy_t2", 32'(bus.all_ready), 32'd1);
    check("drop_err_t2", 32'(bus.seq_error), 32'd0);
    tick(1);
    check("drop_rdy_t3", 32'(bus.all_ready), 32'd0);
    check("drop_err_t3", 32'(bus.seq_error), 32'd1);
    check("drop_stage", 32'(bus.err_stage), 32'd0);
    check("drop_rstn", 32'(bus.stage_reset_n), 32'd7);
    check("drop_state", 32'(bus.dbg_state), 32'(ST_ERROR));
    check("drop_led", 32'(bus.status_led), 32'h5);

    // Restart request from ERROR with ready re-enabled in the same cycle.
    ready_en = 3'b111;
    bus.ext_reset_req = 1'b1;
    tick(1);
    bus.ext_reset_req = 1'b0;
    check("ext_rstn", 32'(bus.stage_reset_n), 32'd0);
    check("ext_seq_error", 32'(bus.seq_error), 32'd0);
    check("ext_all_ready", 32'(bus.all_ready), 32'd0);
    check("ext_state", 32'(bus.dbg_state), 32'(ST_HOLD));
    run_clean("seq2");

    // Stage 1 never ready; asynchronous reset while it waits.
    ready_en = 3'b101;
    do_reset();
    tick(25);
    check("midwait_rstn", 32'(bus.stage_reset_n), 32'd3);
    check("midwait_state", 32'(bus.dbg_state), 32'(ST_WAIT));
    sys_reset = 1'b1;
    #1;
    check("async_rstn", 32'(bus.stage_reset_n), 32'd0);
    check("async_led", 32'(bus.status_led), 32'h8);
    check("async_state", 32'(bus.dbg_state), 32'(ST_HOLD));
    @(negedge sys_clk);
    sys_reset = 1'b0;
    hb_model  = 0;

    // Restarted sequence times out on stage 1.
    tick(8);
    check("to_rstn_t8", 32'(bus.stage_reset_n), 32'd1);
    tick(11);
    check("to_rstn_t19", 32'(bus.stage_reset_n), 32'd3);
    tick(15);
    check("to_err_t34", 32'(bus.seq_error), 32'd0);
    tick(1);
    check("to_err_t35", 32'(bus.seq_error), 32'd1);
    check("to_stage", 32'(bus.err_stage), 32'd1);
    check("to_rstn_t35", 32'(bus.stage_reset_n), 32'd1);
    check("to_led_t35", 32'(bus.status_led), 32'hd);
    tick(10);
    check("to_led_t45", 32'(bus.status_led), 32'hd);
    check("to_state_t45", 32'(bus.dbg_state), 32'(ST_ERROR));

    // Stage 1 ready reaches the FSM on the exact timeout edge (35).
    ready_en = 3'b101;
    do_reset();
    tick(32);
    ready_en = 3'b111;
    tick(2);
    check("edge_state_t34", 32'(bus.dbg_state), 32'(ST_WAIT));
    tick(1);
    check("edge_err_t35", 32'(bus.seq_error), 32'd0);
    check("edge_state_t35", 32'(bus.dbg_state), 32'(ST_HOLD));
    check("edge_rstn_t35", 32'(bus.stage_reset_n), 32'd3);
    tick(8);
    check("edge_rstn_t43", 32'(bus.stage_reset_n), 32'd7);
    tick(3);
    check("edge_rdy_t46", 32'(bus.all_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
